// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment digit scanner.
package seg_scan_pkg;

  localparam int unsigned N_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;
  typedef logic [7:0] seg_t;

  typedef enum logic {
    BLANK,
    DISPLAY
  } scan_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-high segment pattern {a,b,c,d,e,f,g,dot}.
module hex_to_seven_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dot,
  output seg_t       o_seg
);

  logic [6:0] w_abcdefg;

  always_comb begin
    w_abcdefg = 7'b0000000;
    unique case (i_nibble)
      4'h0: w_abcdefg = 7'b1111110;
      4'h1: w_abcdefg = 7'b0110000;
      4'h2: w_abcdefg = 7'b1101101;
      4'h3: w_abcdefg = 7'b1111001;
      4'h4: w_abcdefg = 7'b0110011;
      4'h5: w_abcdefg = 7'b1011011;
      4'h6: w_abcdefg = 7'b1011111;
      4'h7: w_abcdefg = 7'b1110000;
      4'h8: w_abcdefg = 7'b1111111;
      4'h9: w_abcdefg = 7'b1111011;
      4'hA: w_abcdefg = 7'b1110111;
      4'hB: w_abcdefg = 7'b0011111;
      4'hC: w_abcdefg = 7'b1001110;
      4'hD: w_abcdefg = 7'b0111101;
      4'hE: w_abcdefg = 7'b1001111;
      4'hF: w_abcdefg = 7'b1000111;
      default: w_abcdefg = 7'b0000000;
    endcase
  end

  assign o_seg = {w_abcdefg, i_dot};

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner with blanking gaps between digits.
// Define SEG_LEADING_ZERO_BLANK_EN to suppress leading-zero digits (dot still shown).
module seg_digit_scanner
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [4*N_DIGITS-1:0] i_number,
  input  logic [N_DIGITS-1:0]   i_dots,
  output digit_idx_t            o_digit_idx,
  output logic                  o_digit_valid,
  output seg_t                  o_abcdefgh
);

  localparam int unsigned CntW = $clog2(max_u(DIGIT_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_CYCLES - 1);

  scan_state_t     r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  digit_idx_t      r_idx, w_idx_next;
  logic            r_valid, w_valid_next;
  seg_t            r_seg, w_seg_next;

  digit_idx_t w_idx_inc;
  logic [3:0] w_nibble;
  seg_t       w_seg_dec;
  seg_t       w_seg_load;

  // Segment code is looked up for the digit about to be shown, not the current one.
  assign w_idx_inc = r_idx + 2'd1;
  assign w_nibble  = i_number[{w_idx_inc, 2'b00} +: 4];

  hex_to_seven_seg u_hex_to_seven_seg (
    .i_nibble (w_nibble),
    .i_dot    (i_dots[w_idx_inc]),
    .o_seg    (w_seg_dec)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_lz_blank;

  always_comb begin
    w_lz_blank = 1'b0;
    unique case (w_idx_inc)
      2'd1:    w_lz_blank = (i_number[15:4] == 12'h000);
      2'd2:    w_lz_blank = (i_number[15:8] == 8'h00);
      2'd3:    w_lz_blank = (i_number[15:12] == 4'h0);
      default: w_lz_blank = 1'b0;
    endcase
  end

  assign w_seg_load = w_lz_blank ? {7'b0000000, w_seg_dec[0]} : w_seg_dec;
`else
  assign w_seg_load = w_seg_dec;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= 2'd3;
      r_valid <= 1'b0;
      r_seg   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_valid <= w_valid_next;
      r_seg   <= w_seg_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_valid_next = r_valid;
    w_seg_next   = r_seg;
    if (!i_en) begin
      w_state_next = BLANK;
      w_cnt_next   = '0;
      w_valid_next = 1'b0;
      w_seg_next   = '0;
    end else begin
      unique case (r_state)
        BLANK: begin
          if (r_cnt == BlankLast) begin
            w_state_next = DISPLAY;
            w_cnt_next   = '0;
            w_idx_next   = w_idx_inc;
            w_valid_next = 1'b1;
            w_seg_next   = w_seg_load;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        DISPLAY: begin
          if (r_cnt == DigitLast) begin
            w_state_next = BLANK;
            w_cnt_next   = '0;
            w_valid_next = 1'b0;
            w_seg_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: w_state_next = BLANK;
      endcase
    end
  end

  assign o_digit_idx   = r_idx;
  assign o_digit_valid = r_valid;
  assign o_abcdefgh    = r_seg;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner with DIGIT_CYCLES=4, BLANK_CYCLES=2.
module tb_seg_digit_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] number;
  logic [3:0]  dots;
  logic [1:0]  digit_idx;
  logic        digit_valid;
  logic [7:0]  abcdefgh;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] Seg0  = 8'b11111100;
  localparam logic [7:0] Seg1  = 8'b01100000;
  localparam logic [7:0] Seg2  = 8'b11011010;
  localparam logic [7:0] Seg3  = 8'b11110010;
  localparam logic [7:0] Seg4  = 8'b01100110;
  localparam logic [7:0] Seg5  = 8'b10110110;
  localparam logic [7:0] SegF  = 8'b10001110;
  localparam logic [7:0] Seg8  = 8'hFE;
  localparam logic [7:0] Seg8D = 8'hFF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] SegLz = 8'h00;
`else
  localparam logic [7:0] SegLz = Seg0;
`endif

  seg_digit_scanner #(
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_number      (number),
    .i_dots        (dots),
    .o_digit_idx   (digit_idx),
    .o_digit_valid (digit_valid),
    .o_abcdefgh    (abcdefgh)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] idx,
                           input logic [7:0] seg);
    check_eq({tag, ".valid"}, {31'd0, digit_valid}, {31'd0, v});
    check_eq({tag, ".idx"}, {30'd0, digit_idx}, {30'd0, idx});
    check_eq({tag, ".seg"}, {24'd0, abcdefgh}, {24'd0, seg});
  endtask

  task automatic disp(input logic [1:0] idx, input logic [7:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      check_out("disp", 1'b1, idx, seg);
      tick();
    end
  endtask

  task automatic blank_gap(input logic [1:0] idx);
    for (int i = 0; i < 2; i++) begin
      check_out("blank", 1'b0, idx, 8'h00);
      tick();
    end
  endtask

  task automatic run_digit(input logic [1:0] idx, input logic [7:0] seg);
    disp(idx, seg, 4);
    blank_gap(idx);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b1;
    number = 16'h1234;
    dots   = 4'b0000;
    tick();
    tick();
    check_out("reset", 1'b0, 2'd3, 8'h00);

    // First digit appears BLANK_CYCLES edges after reset release.
    rst = 1'b0;
    tick();
    check_out("first_blank", 1'b0, 2'd3, 8'h00);
    tick();
    run_digit(2'd0, Seg4);
    run_digit(2'd1, Seg3);
    run_digit(2'd2, Seg2);
    run_digit(2'd3, Seg1);
    run_digit(2'd0, Seg4);

    // Input changes mid-digit must not tear the captured pattern.
    number = 16'h0000;
    run_digit(2'd1, Seg3);
    run_digit(2'd2, Seg0);
    run_digit(2'd3, Seg0);
    disp(2'd0, Seg0, 1);
    number = 16'hFFFF;
    disp(2'd0, Seg0, 3);
    blank_gap(2'd0);
    run_digit(2'd1, SegF);

    // Dot routing.
    dots   = 4'b0100;
    number = 16'h8888;
    run_digit(2'd2, SegF);
    run_digit(2'd3, Seg8);
    run_digit(2'd0, Seg8);
    run_digit(2'd1, Seg8);
    run_digit(2'd2, Seg8D);
    run_digit(2'd3, Seg8);
    run_digit(2'd0, Seg8);
    run_digit(2'd1, Seg8);

    // Enable dropped mid-digit 2.
    disp(2'd2, Seg8D, 2);
    en = 1'b0;
    tick();
    check_out("en_off", 1'b0, 2'd2, 8'h00);
    tick();
    check_out("en_off_hold", 1'b0, 2'd2, 8'h00);
    en = 1'b1;
    tick();
    check_out("en_back_blank", 1'b0, 2'd2, 8'h00);
    tick();
    run_digit(2'd3, Seg8);

    // Reset mid-digit 1 restarts the scan from digit 0.
    run_digit(2'd0, Seg8);
    disp(2'd1, Seg8, 2);
    rst = 1'b1;
    tick();
    check_out("mid_reset", 1'b0, 2'd3, 8'h00);
    rst = 1'b0;
    tick();
    check_out("post_reset_blank", 1'b0, 2'd3, 8'h00);
    tick();
    disp(2'd0, Seg8, 4);

    // Leading-zero handling.
    number = 16'h0050;
    dots   = 4'b0000;
    blank_gap(2'd0);
    run_digit(2'd1, Seg5);
    run_digit(2'd2, SegLz);
    run_digit(2'd3, SegLz);
    run_digit(2'd0, Seg0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
